minipit_multi: RTL and testbench

Multi-channel programmable interval timer, the parametrised successor of the single-channel minipit. Provides CHANNELS independent down-counting timers of WIDTH bits, each with its own prescaler, one-shot/periodic mode, sticky pending flag with acknowledge, and maskable interrupt. It sits behind a simple synchronous register-write port driven by the host/config logic and feeds interrupt lines to the top-level status outputs.

---
 rtl/minipit_multi.sv | 155 +++++++++++++++
 tb/tb_minipit_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/minipit_multi.sv
// minipit_multi: multi-channel programmable interval timer.
// Each channel is an independent down-counter with its own prescaler,
// one-shot or periodic mode, a sticky pending flag, and a maskable irq.
// Registers are reached through a write-only port:
// wr_addr = {channel, reg}.
//   reg 0 CTRL     {bit2 irq_en, bit1 periodic, bit0 enable}
//   reg 1 RELOAD   WIDTH bits
//   reg 2 PRESCALE PRE_W bits (taken from the LSBs of wr_data, PRE_W <= WIDTH)
//   reg 3 reserved, writes ignored
module minipit_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRE_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ADDR_W  = CH_W + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [CHANNELS-1:0]       irq_ack,
  output logic [CHANNELS-1:0]       irq,
  output logic [CHANNELS-1:0]       expire,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS*WIDTH-1:0] count
);

  logic [CH_W-1:0] wr_ch_s;
  logic [1:0]      wr_reg_s;

  assign wr_ch_s  = wr_addr[ADDR_W-1:2];
  assign wr_reg_s = wr_addr[1:0];

  // Channel indices at or above CHANNELS never match a generated channel,
  // so such writes fall on the floor without any extra decode.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             running_r,  running_s;
    logic             periodic_r, periodic_s;
    logic             irq_en_r,   irq_en_s;
    logic             pending_r,  pending_s;
    logic             irq_r,      irq_s;
    logic             expire_r,   expire_s;
    logic [WIDTH-1:0] reload_r,   reload_s;
    logic [WIDTH-1:0] count_r,    count_s;
    logic [PRE_W-1:0] prescale_r, prescale_s;
    logic [PRE_W-1:0] act_pre_r,  act_pre_s;
    logic [PRE_W-1:0] pre_cnt_r,  pre_cnt_s;
    logic             wr_hit_s;
    logic             ctrl_wr_s;
    logic             tick_s;

    assign wr_hit_s = wr_en && (wr_ch_s == CH_W'(i));
    // act_pre_r is the prescale value in force for the current prescaler
    // cycle; new PRESCALE writes are picked up only at a wrap or an enable,
    // so a smaller value written mid-cycle cannot make pre_cnt overrun.
    assign tick_s   = running_r && (pre_cnt_r == act_pre_r);

    // Next-state: register writes, enable/disable, prescaler, count, expiry.
    always_comb begin
      periodic_s = periodic_r;
      irq_en_s   = irq_en_r;
      reload_s   = reload_r;
      prescale_s = prescale_r;
      running_s  = running_r;
      count_s    = count_r;
      pre_cnt_s  = pre_cnt_r;
      act_pre_s  = act_pre_r;
      expire_s   = 1'b0;
      ctrl_wr_s  = 1'b0;

      if (wr_hit_s) begin
        case (wr_reg_s)
          2'd0: begin
            ctrl_wr_s  = 1'b1;
            periodic_s = wr_data[1];
            irq_en_s   = wr_data[2];
          end
          2'd1:    reload_s   = wr_data;
          2'd2:    prescale_s = wr_data[PRE_W-1:0];
          default: ctrl_wr_s  = 1'b0;
        endcase
      end else begin
        ctrl_wr_s = 1'b0;
      end

      if (ctrl_wr_s && !wr_data[0]) begin
        // Disable wins over a coincident expiry; count and pre_cnt hold.
        running_s = 1'b0;
      end else if (ctrl_wr_s && !running_r) begin
        // Fresh enable: load the counter and restart the prescaler.
        running_s = 1'b1;
        count_s   = reload_r;
        pre_cnt_s = {PRE_W{1'b0}};
        act_pre_s = prescale_r;
      end else if (tick_s) begin
        pre_cnt_s = {PRE_W{1'b0}};
        act_pre_s = prescale_r;
        if (count_r != {WIDTH{1'b0}}) begin
          count_s = count_r - WIDTH'(1);
        end else begin
          expire_s = 1'b1;
          if (periodic_r) begin
            count_s = reload_r;
          end else begin
            running_s = 1'b0;
          end
        end
      end else if (running_r) begin
        pre_cnt_s = pre_cnt_r + PRE_W'(1);
      end else begin
        running_s = running_r;
      end

      // A new expiry beats an acknowledge arriving in the same cycle.
      pending_s = (pending_r & ~irq_ack[i]) | expire_s;
      irq_s     = pending_s & irq_en_s;
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        running_r  <= 1'b0;
        periodic_r <= 1'b0;
        irq_en_r   <= 1'b0;
        pending_r  <= 1'b0;
        irq_r      <= 1'b0;
        expire_r   <= 1'b0;
        reload_r   <= {WIDTH{1'b0}};
        count_r    <= {WIDTH{1'b0}};
        prescale_r <= {PRE_W{1'b0}};
        act_pre_r  <= {PRE_W{1'b0}};
        pre_cnt_r  <= {PRE_W{1'b0}};
      end else begin
        running_r  <= running_s;
        periodic_r <= periodic_s;
        irq_en_r   <= irq_en_s;
        pending_r  <= pending_s;
        irq_r      <= irq_s;
        expire_r   <= expire_s;
        reload_r   <= reload_s;
        count_r    <= count_s;
        prescale_r <= prescale_s;
        act_pre_r  <= act_pre_s;
        pre_cnt_r  <= pre_cnt_s;
      end
    end

    assign irq[i]                   = irq_r;
    assign expire[i]                = expire_r;
    assign running[i]               = running_r;
    assign count[i*WIDTH +: WIDTH]  = count_r;
  end

endmodule

// File: tb/tb_minipit_multi.sv
// Directed bench for minipit_multi, three channels of 16 bits.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// so every check observes the state produced by the edge just passed.
module tb_minipit_multi;

  localparam int CH = 3;
  localparam int W  = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] irq_ack;
  logic [CH-1:0] irq;
  logic [CH-1:0] expire;
  logic [CH-1:0] running;
  logic [CH*W-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  minipit_multi #(.CHANNELS(CH), .WIDTH(W), .PRE_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .irq_ack (irq_ack),
    .irq     (irq),
    .expire  (expire),
    .running (running),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 16'd0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 16'd0;
    irq_ack = 3'b000;

    // Reset state
    step(2);
    chk("rst_irq",     {61'd0, irq},     64'd0);
    chk("rst_expire",  {61'd0, expire},  64'd0);
    chk("rst_running", {61'd0, running}, 64'd0);
    chk("rst_count",   {16'd0, count},   64'd0);
    rst_n = 1'b1;
    step(1);

    // Periodic ch0, RELOAD=3, PRESCALE=0
    wr(4'b0001, 16'd3);
    wr(4'b0000, 16'b011);        // edge T
    chk("p0_running", {63'd0, running[0]}, 64'd1);
    chk("p0_count_T", {48'd0, cnt(0)}, 64'd3);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk($sformatf("p0_count_T+%0d", k), {48'd0, cnt(0)},
          (k % 4 == 0) ? 64'd3 : 64'(3 - (k % 4)));
      chk($sformatf("p0_expire_T+%0d", k), {63'd0, expire[0]},
          (k % 4 == 0) ? 64'd1 : 64'd0);
    end
    chk("p0_irq_masked", {63'd0, irq[0]}, 64'd0);
    wr(4'b0000, 16'b000);        // disable at T+13
    chk("p0_dis_running", {63'd0, running[0]}, 64'd0);
    chk("p0_dis_count",   {48'd0, cnt(0)}, 64'd3);
    step(2);
    chk("p0_dis_hold", {48'd0, cnt(0)}, 64'd3);
    irq_ack = 3'b001;            // clear stale pending on ch0
    step(1);
    irq_ack = 3'b000;

    // One-shot ch1, RELOAD=5, PRESCALE=2, irq enabled
    wr(4'b0101, 16'd5);
    wr(4'b0110, 16'd2);
    wr(4'b0100, 16'b101);        // edge T
    step(3);
    chk("os1_count_T+3", {48'd0, cnt(1)}, 64'd4);
    step(14);                    // T+17
    chk("os1_count_T+17",  {48'd0, cnt(1)}, 64'd0);
    chk("os1_expire_T+17", {63'd0, expire[1]}, 64'd0);
    chk("os1_run_T+17",    {63'd0, running[1]}, 64'd1);
    step(1);                     // T+18
    chk("os1_expire_T+18", {63'd0, expire[1]}, 64'd1);
    chk("os1_irq_T+18",    {63'd0, irq[1]}, 64'd1);
    chk("os1_run_T+18",    {63'd0, running[1]}, 64'd0);
    step(3);
    chk("os1_expire_after", {63'd0, expire[1]}, 64'd0);
    chk("os1_count_held",   {48'd0, cnt(1)}, 64'd0);
    chk("os1_irq_sticky",   {63'd0, irq[1]}, 64'd1);
    irq_ack = 3'b010;
    step(1);
    irq_ack = 3'b000;
    chk("os1_irq_acked", {63'd0, irq[1]}, 64'd0);

    // Ack collision on ch0, RELOAD=1 periodic with irq
    wr(4'b0001, 16'd1);
    wr(4'b0000, 16'b111);        // edge T
    step(1);                     // T+1
    chk("ac_irq_T+1", {63'd0, irq[0]}, 64'd0);
    step(1);                     // T+2 expiry
    chk("ac_expire_T+2", {63'd0, expire[0]}, 64'd1);
    chk("ac_irq_T+2",    {63'd0, irq[0]}, 64'd1);
    step(1);                     // T+3
    irq_ack = 3'b001;
    step(1);                     // T+4: expiry and ack together
    chk("ac_expire_T+4", {63'd0, expire[0]}, 64'd1);
    chk("ac_irq_set_wins", {63'd0, irq[0]}, 64'd1);
    step(1);                     // T+5: ack alone
    chk("ac_irq_cleared", {63'd0, irq[0]}, 64'd0);
    irq_ack = 3'b000;
    wr(4'b0000, 16'b000);        // T+6: disable on an expiry edge
    chk("dis_wins_expire",  {63'd0, expire[0]}, 64'd0);
    chk("dis_wins_irq",     {63'd0, irq[0]}, 64'd0);
    chk("dis_wins_running", {63'd0, running[0]}, 64'd0);
    chk("dis_wins_count",   {48'd0, cnt(0)}, 64'd0);

    // Mid-run RELOAD change on ch2
    wr(4'b1001, 16'd7);
    wr(4'b1000, 16'b011);        // edge T
    step(3);                     // T+3
    chk("mr_count_T+3", {48'd0, cnt(2)}, 64'd4);
    wr(4'b1001, 16'd2);          // T+4
    chk("mr_count_T+4", {48'd0, cnt(2)}, 64'd3);
    step(3);                     // T+7
    chk("mr_expire_T+7", {63'd0, expire[2]}, 64'd0);
    step(1);                     // T+8
    chk("mr_expire_T+8", {63'd0, expire[2]}, 64'd1);
    chk("mr_reload_new", {48'd0, cnt(2)}, 64'd2);
    step(2);                     // T+10
    chk("mr_expire_T+10", {63'd0, expire[2]}, 64'd0);
    step(1);                     // T+11
    chk("mr_expire_T+11", {63'd0, expire[2]}, 64'd1);
    step(3);                     // T+14
    chk("mr_expire_T+14", {63'd0, expire[2]}, 64'd1);

    // Isolation: writes to absent channel 3, then to ch0
    wr(4'b1100, 16'b111);        // T+15
    wr(4'b1101, 16'd5);          // T+16
    wr(4'b0001, 16'd9);          // T+17
    chk("iso_expire2",  {63'd0, expire[2]}, 64'd1);
    chk("iso_count2",   {48'd0, cnt(2)}, 64'd2);
    chk("iso_running",  {61'd0, running}, 64'b100);
    chk("iso_count0",   {48'd0, cnt(0)}, 64'd0);
    chk("iso_count1",   {48'd0, cnt(1)}, 64'd0);
    chk("iso_irq",      {61'd0, irq}, 64'd0);

    // Reset mid-count with all channels running
    wr(4'b0000, 16'b011);
    wr(4'b0100, 16'b001);
    step(2);
    chk("pre_rst_running", {61'd0, running}, 64'b111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_running", {61'd0, running}, 64'd0);
    chk("async_rst_count",   {16'd0, count}, 64'd0);
    chk("async_rst_irq",     {61'd0, irq}, 64'd0);
    chk("async_rst_expire",  {61'd0, expire}, 64'd0);
    step(3);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step(1);
      chk($sformatf("post_rst_idle_%0d", k), {58'd0, expire, running}, 64'd0);
    end

    // RELOAD=0 after reset: expiry on every tick
    wr(4'b0000, 16'b011);        // edge T
    step(1);
    chk("r0_expire_T+1", {63'd0, expire[0]}, 64'd1);
    step(1);
    chk("r0_expire_T+2", {63'd0, expire[0]}, 64'd1);
    chk("r0_count",      {48'd0, cnt(0)}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
